// File: rtl/remote_sched_pkg.sv
// Shared types and constants for the remote command scheduler.
package remote_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SEND      = 3'd1,
    S_WAIT_SENT = 3'd2,
    S_WAIT_RESP = 3'd3,
    S_DONE      = 3'd4
  } sched_state_t;

  localparam logic [7:0] DEF_ACK_VAL = 8'hA5;
  localparam int         MAX_NUM_REQ = 4;
  localparam int         CMD_W       = 16;
  // Requester indices are always carried at the width needed for the largest supported NUM_REQ.
  localparam int         IDX_W       = $clog2(MAX_NUM_REQ);

endpackage

// File: rtl/rr_arb.sv
// Round-robin arbiter: combinational pick starting one past the last served
// requester, with the served index registered as the new pointer on ack.
module rr_arb
  import remote_sched_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_upd,
  input  logic [IDX_W-1:0]   i_upd_idx,
  output logic               o_gnt_vld,
  output logic [IDX_W-1:0]   o_gnt_idx
);

  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] w_cand [NUM_REQ];

  // w_cand[g] is the requester examined at search distance g+1 from the pointer.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_cand
    assign w_cand[g] = IDX_W'((32'(r_ptr) + g + 1) % NUM_REQ);
  end

  // Walk from the farthest candidate down so the nearest requester wins.
  always_comb begin
    o_gnt_vld = 1'b0;
    o_gnt_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (i_req[w_cand[k]]) begin
        o_gnt_vld = 1'b1;
        o_gnt_idx = w_cand[k];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (i_upd) begin
      r_ptr <= i_upd_idx;
    end
  end

endmodule

// File: rtl/remote_cmd_sched.sv
// Shares one remote command link between NUM_REQ requesters with a response timeout.
// Optional resend-on-timeout is compiled in with REMOTE_SCHED_RETRY_EN.
module remote_cmd_sched
  import remote_sched_pkg::*;
#(
  parameter int         NUM_REQ     = 2,
  parameter int         TIMEOUT_CYC = 2000000,
  parameter logic [7:0] ACK_VAL     = DEF_ACK_VAL
`ifdef REMOTE_SCHED_RETRY_EN
  ,
  parameter int         MAX_RETRY   = 1
`endif
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*CMD_W-1:0] req_cmd,
  output logic [NUM_REQ-1:0]       ack,
  output logic                     busy,
  output logic [7:0]               rsp_byte,
  output logic                     rsp_ok,
  output logic                     rsp_tmo,
  output logic                     send_cmd,
  output logic [CMD_W-1:0]         cmd,
  input  logic                     cmd_sent,
  input  logic                     resp_rdy,
  input  logic [7:0]               resp,
  output logic [2:0]               dbg_state
);

  localparam int               CNT_W    = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(TIMEOUT_CYC - 1);

  sched_state_t     r_state;
  logic [CMD_W-1:0] r_cmd;
  logic [IDX_W-1:0] r_gnt;
  logic [CNT_W-1:0] r_cnt;
  logic [7:0]       r_rsp_byte;
  logic             r_rsp_ok;
  logic             r_rsp_tmo;

  logic             w_gnt_vld;
  logic [IDX_W-1:0] w_gnt_idx;
  logic             w_retry;
  logic [CMD_W-1:0] w_slot [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slot
    assign w_slot[i] = req_cmd[CMD_W*i +: CMD_W];
  end

  rr_arb #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_req     (req),
    .i_upd     (r_state == S_DONE),
    .i_upd_idx (r_gnt),
    .o_gnt_vld (w_gnt_vld),
    .o_gnt_idx (w_gnt_idx)
  );

`ifdef REMOTE_SCHED_RETRY_EN
  localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  logic [RTY_W-1:0] r_retry;

  assign w_retry = (r_retry < RTY_W'(MAX_RETRY));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_retry <= '0;
    end else if (r_state == S_IDLE && w_gnt_vld) begin
      r_retry <= '0;
    end else if (r_state == S_WAIT_RESP && !resp_rdy && r_cnt == CNT_TERM && w_retry) begin
      r_retry <= r_retry + 1'b1;
    end
  end
`else
  assign w_retry = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cmd      <= '0;
      r_gnt      <= '0;
      r_cnt      <= '0;
      r_rsp_byte <= '0;
      r_rsp_ok   <= 1'b0;
      r_rsp_tmo  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_gnt_vld) begin
            r_cmd   <= w_slot[w_gnt_idx];
            r_gnt   <= w_gnt_idx;
            r_state <= S_SEND;
          end
        end
        S_SEND: r_state <= S_WAIT_SENT;
        S_WAIT_SENT: begin
          if (cmd_sent) begin
            r_cnt   <= '0;
            r_state <= S_WAIT_RESP;
          end
        end
        S_WAIT_RESP: begin
          // A response arriving on the terminal count still wins over the timeout.
          if (resp_rdy) begin
            r_rsp_byte <= resp;
            r_rsp_ok   <= (resp == ACK_VAL);
            r_rsp_tmo  <= 1'b0;
            r_state    <= S_DONE;
          end else if (r_cnt == CNT_TERM) begin
            if (w_retry) begin
              r_state <= S_SEND;
            end else begin
              r_rsp_byte <= 8'h00;
              r_rsp_ok   <= 1'b0;
              r_rsp_tmo  <= 1'b1;
              r_state    <= S_DONE;
            end
          end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    ack = '0;
    if (r_state == S_DONE) ack[r_gnt] = 1'b1;
  end

  assign busy      = (r_state != S_IDLE);
  assign send_cmd  = (r_state == S_SEND);
  assign cmd       = r_cmd;
  assign rsp_byte  = r_rsp_byte;
  assign rsp_ok    = r_rsp_ok;
  assign rsp_tmo   = r_rsp_tmo;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_remote_cmd_sched.sv
// Directed plus randomized bench for remote_cmd_sched with a cycle-level link model
// and an outcome model derived from the scheduler's arbitration and timing rules.
module tb_remote_cmd_sched;

  localparam int         N    = 3;
  localparam int         T    = 16;
  localparam logic [7:0] ACKV = 8'hA5;
`ifdef REMOTE_SCHED_RETRY_EN
  localparam int RETRIES = 1;
`else
  localparam int RETRIES = 0;
`endif

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req;
  logic [N*16-1:0] req_cmd;
  logic [N-1:0]    ack;
  logic            busy;
  logic [7:0]      rsp_byte;
  logic            rsp_ok;
  logic            rsp_tmo;
  logic            send_cmd;
  logic [15:0]     cmd;
  logic            cmd_sent;
  logic            resp_rdy;
  logic [7:0]      resp;
  logic [2:0]      dbg_state;

  remote_cmd_sched #(
    .NUM_REQ     (N),
    .TIMEOUT_CYC (T),
    .ACK_VAL     (ACKV)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_cmd   (req_cmd),
    .ack       (ack),
    .busy      (busy),
    .rsp_byte  (rsp_byte),
    .rsp_ok    (rsp_ok),
    .rsp_tmo   (rsp_tmo),
    .send_cmd  (send_cmd),
    .cmd       (cmd),
    .cmd_sent  (cmd_sent),
    .resp_rdy  (resp_rdy),
    .resp      (resp),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int          total = 0;
  int          bad   = 0;
  int          m_last = 0;
  logic [17:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, obs, expv);
    end
  endtask

  // Reference arbitration: first requester found searching upward from last served + 1.
  function automatic int pick(input logic [N-1:0] rq, input int last);
    int j;
    for (int k = 1; k <= N; k++) begin
      j = (last + k) % N;
      if (((rq >> j) & 1) != 0) return j;
    end
    return -1;
  endfunction

  // One complete transaction: present requests, play the link, check the outcome.
  // dly < 0 means the link never answers.
  task automatic run_txn(input logic [N-1:0] rq, input int lat, input int dly,
                         input logic [7:0] val, input bit stray);
    int          w, nsend, ack_at, sends, raise_at, rsp_at, stray_at;
    bit          seen, rsp_given;
    logic [15:0] cmd0;
    logic [17:0] e;
    logic [7:0]  eb;
    logic        eok, etmo;
    w    = pick(rq, m_last);
    cmd0 = 16'($urandom);
    for (int i = 0; i < N; i++) req_cmd[16*i +: 16] = (i == w) ? cmd0 : 16'($urandom);
    req = rq;
    if (dly >= 0 && dly < T) begin
      eb = val; eok = (val == ACKV); etmo = 1'b0; nsend = 1;
      ack_at = lat + dly + 3;
    end else begin
      eb = 8'h00; eok = 1'b0; etmo = 1'b1; nsend = 1 + RETRIES;
      ack_at = 1 + nsend * (lat + 1 + T);
    end
    exp_q.push_back({8'(w), eb, eok, etmo});
    sends = 0; raise_at = -1; rsp_at = -1; stray_at = -1; seen = 1'b0; rsp_given = 1'b0;
    for (int cyc = 1; cyc <= 200 && !seen; cyc++) begin
      @(negedge clk);
      resp_rdy = 1'b0;
      resp     = 8'($urandom);
      if (ack != '0) begin
        seen = 1'b1;
        e = exp_q.pop_front();
        chk("ack_onehot", 32'(ack), 32'(1) << e[17:10]);
        chk("ack_cycle", cyc, ack_at);
        chk("send_count", sends, nsend);
        chk("rsp_byte", 32'(rsp_byte), 32'(e[9:2]));
        chk("rsp_ok", 32'(rsp_ok), 32'(e[1]));
        chk("rsp_tmo", 32'(rsp_tmo), 32'(e[0]));
        chk("busy_at_ack", 32'(busy), 32'd1);
        m_last = w;
      end else begin
        chk("cmd_hold", 32'(cmd), 32'(cmd0));
        if (cyc == 1) begin
          chk("busy_grant", 32'(busy), 32'd1);
          chk("send_first", 32'(send_cmd), 32'd1);
          req_cmd = 48'({$urandom, $urandom});
        end
        if (send_cmd) begin
          sends++;
          cmd_sent = 1'b0;
          raise_at = cyc + lat;
          if (stray) stray_at = cyc + 1;
        end
        if (cyc == stray_at) begin
          resp_rdy = 1'b1;
          resp     = val ^ 8'h0F;
        end
        if (cyc == raise_at) begin
          cmd_sent = 1'b1;
          if (dly >= 0 && !rsp_given) begin
            rsp_at    = cyc + 1 + dly;
            rsp_given = 1'b1;
          end
        end
        if (cyc == rsp_at) begin
          resp_rdy = 1'b1;
          resp     = val;
        end
      end
    end
    if (!seen) begin
      chk("ack_seen", 32'd0, 32'd1);
      void'(exp_q.pop_back());
    end
    req      = '0;
    resp_rdy = 1'b0;
    cmd_sent = 1'b1;
    @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_ack", 32'(ack), 32'd0);
    chk("rsp_hold", 32'(rsp_byte), 32'(eb));
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_ack"},      32'(ack),      32'd0);
    chk({pfx, "_busy"},     32'(busy),     32'd0);
    chk({pfx, "_send_cmd"}, 32'(send_cmd), 32'd0);
    chk({pfx, "_cmd"},      32'(cmd),      32'd0);
    chk({pfx, "_rsp_byte"}, 32'(rsp_byte), 32'd0);
    chk({pfx, "_rsp_ok"},   32'(rsp_ok),   32'd0);
    chk({pfx, "_rsp_tmo"},  32'(rsp_tmo),  32'd0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [N-1:0] rq;
    int           d;
    rst_n    = 1'b1;
    req      = '0;
    req_cmd  = '0;
    cmd_sent = 1'b1;
    resp_rdy = 1'b0;
    resp     = 8'h00;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // single request, positive acknowledge
    run_txn(3'b001, 2, 3, 8'hA5, 1'b0);
    // negative response
    run_txn(3'b010, 1, 0, 8'h5A, 1'b0);
    // contention between two requesters held high
    for (int t = 0; t < 4; t++) run_txn(3'b011, 2, 2, 8'hA5, 1'b0);
    // no response: timeout
    run_txn(3'b100, 3, -1, 8'h00, 1'b0);
    // stray byte during WAIT_SENT plus response on the terminal count
    run_txn(3'b001, 2, T - 1, 8'h3C, 1'b1);

    // reset while waiting for cmd_sent
    req     = 3'b100;
    req_cmd = 48'({$urandom, $urandom}) | 48'h8000_8000_8000;
    @(negedge clk);
    cmd_sent = 1'b0;
    @(negedge clk);
    chk("pre_reset_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("midrst");
    req      = '0;
    cmd_sent = 1'b1;
    m_last   = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    // fresh request after reset; pointer restarts at 0 so requester 1 wins
    run_txn(3'b011, 2, 4, 8'hA5, 1'b0);

    // randomized traffic
    for (int t = 0; t < 20; t++) begin
      rq = N'($urandom_range(1, (1 << N) - 1));
      d  = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, T - 1));
      run_txn(rq, int'($urandom_range(1, 5)), d,
              ($urandom_range(0, 1) == 1) ? ACKV : 8'($urandom),
              1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/remote_cmd_sched.md
# remote_cmd_sched

Round-robin scheduler that shares a single remote command link (16-bit command out over UART as high then low byte, 8-bit response back) between NUM_REQ requesters. It latches the winning requester's command and drives the link's send handshake. It then waits for the response and enforces a response timeout. The outcome (response byte, ack-match flag, timeout flag) is returned to the granted requester. It sits between the remote-side test sequencers and the remote comm transceiver.

## Interface
- NUM_REQ, 2, number of requesters (2..4)
- TIMEOUT_CYC, 2000000, clocks allowed in WAIT_RESP before timeout
- ACK_VAL, 8'hA5, response value counted as positive acknowledge
- MAX_RETRY, 1, resends after timeout (used only with retry compiled in)

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- req  input  NUM_REQ  per-requester request level; held until that requester's ack
- req_cmd  input  NUM_REQ×16  packed commands; slot i = bits [16i+15:16i]
- ack  output  NUM_REQ  one-cycle done pulse to the granted requester
- busy  output  1  high from grant until ack
- rsp_byte  output  8  last response (0x00 on timeout); valid with ack, held after
- rsp_ok  output  1  rsp_byte == ACK_VAL and no timeout; valid with ack, held
- rsp_tmo  output  1  transaction ended by timeout; valid with ack, held
- send_cmd  output  1  one-cycle pulse to link starting transmission
- cmd  output  16  command to link; stable from send_cmd until cmd_sent
- cmd_sent  input  1  link level: cleared by send_cmd, set when both bytes are out
- resp_rdy  input  1  link one-cycle pulse: response byte valid
- resp  input  8  response byte from link

## Operation
- States: IDLE, SEND, WAIT_SENT, WAIT_RESP, DONE.
- IDLE, any req high:
  - Arbiter picks the winner round-robin, searching upward from (last granted + 1) mod NUM_REQ; pointer resets to 0.
  - The winner's req_cmd is latched into cmd_q and its index into gnt_q. Go to SEND.
- SEND: send_cmd=1 for exactly one cycle. Go to WAIT_SENT.
- WAIT_SENT: hold until cmd_sent=1. Then clear the timeout counter and go to WAIT_RESP.
- WAIT_RESP:
  - resp_rdy: capture resp, set rsp_ok=(resp==ACK_VAL), rsp_tmo=0. Go to DONE.
  - Otherwise the counter increments. At count == TIMEOUT_CYC-1: rsp_byte=0, rsp_ok=0, rsp_tmo=1. Go to DONE.
  - resp_rdy on the same cycle as the terminal count: the response wins.
- DONE: ack[gnt_q]=1 for one cycle; pointer updates to gnt_q. Go to IDLE.
- cmd drives cmd_q at all times, so requesters may change req_cmd once busy rises.
- resp_rdy outside WAIT_RESP is ignored (stray or late bytes dropped).
- A req deasserted before grant is simply not served. Deassertion after grant does not abort the transaction.
- Timeout counter width is $clog2(TIMEOUT_CYC)+1, saturating, no wrap.

## Timing
- Reset values: state IDLE; ack=0, busy=0, send_cmd=0, cmd=0, rsp_byte=0, rsp_ok=0, rsp_tmo=0; pointer 0, counter 0.
- req high in IDLE at edge N: busy=1 and cmd valid after N; send_cmd high during cycle N+1.
- ack pulses the cycle after the response is captured (resp_rdy at edge M → ack high during cycle M+1).
- Back-to-back: next grant at the earliest in the cycle after ack, so idle gap = 1 cycle.
- Reset mid-transaction: immediate return to IDLE, no ack issued. Link is assumed reset together.

## Configuration
- REMOTE_SCHED_RETRY_EN defined:
  - On timeout, if retry_cnt < MAX_RETRY: increment retry_cnt and return to SEND with the same cmd_q, without ack.
  - rsp_tmo is reported only after retries are exhausted. retry_cnt clears at grant.
- Undefined: the first timeout goes directly to DONE; no retry counter is instantiated.

## Structure
- Package remote_sched_pkg: state enum sched_state_t, default ACK_VAL constant, NUM_REQ max.
- Sub-module rr_arb: combinational round-robin grant from req and pointer, plus the registered pointer update on ack.

## Test plan
- Single request, NUM_REQ=2: req[0]=1, req_cmd slot 0=16'h2345; link model returns 8'hA5 → send_cmd pulse once, cmd=16'h2345 held until cmd_sent, ack[0] pulse, rsp_ok=1, rsp_tmo=0.
- Contention: req=2'b11 continuously, cmds 16'h1111/16'h2222 → grants alternate 0,1,0,1; four acks, no starvation.
- Negative response: link returns 8'h5A → ack, rsp_byte=8'h5A, rsp_ok=0, rsp_tmo=0.
- Timeout, TIMEOUT_CYC=16, no response → ack 16 cycles after entering WAIT_RESP, rsp_tmo=1, rsp_byte=0. With REMOTE_SCHED_RETRY_EN: exactly two send_cmd pulses before ack.
- Race and strays: resp_rdy pulsed during WAIT_SENT is ignored. resp_rdy coincident with the terminal count gives rsp_tmo=0, rsp_byte captured.
- Reset asserted in WAIT_SENT → all outputs return to reset values asynchronously. After release, a fresh request completes normally.
